// File: rtl/util_pkg.sv
// Shared types and helpers for the tile feeder slice.
// Holds FSM encoding, packed row width and a clog2 helper.
package util_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } feed_state_t;

    function automatic int FULL_WIDTH(input int ew, input int ec);
        return ew * ec;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/util_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// Pointers wrap naturally; the count register resolves full/empty.
module util_sync_fifo
    import util_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/util_tile_feeder.sv
// Buffers incoming rows and issues one tile plus flush rows
// into the systolic skew loader per start request.
module util_tile_feeder
    import util_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 16,
    parameter int ELEMENT_COUNT = 4,
    parameter int FIFO_DEPTH    = 8,
    localparam int W = FULL_WIDTH(ELEMENT_WIDTH, ELEMENT_COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] packed_out,
    output logic         load_ena,
    output logic         busy,
    output logic         done
);

    localparam int CW  = clog2(FIFO_DEPTH + 1);
    localparam int NW  = clog2(ELEMENT_COUNT + 1);

    feed_state_t   state, state_n;
    logic [NW-1:0] row_cnt, row_n;
    logic [NW-1:0] flush_cnt, flush_n;
    logic          push, pop, ld, zero, done_n;
    logic [W-1:0]  head;
    logic [CW-1:0] count, count_n;
    logic          full, empty;

    assign push    = s_valid && s_ready;
    assign count_n = count + CW'(push) - CW'(pop);
    assign busy    = (state != IDLE);

    util_sync_fifo #(
        .WIDTH(W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (s_data),
        .dout (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        state_n = state;
        row_n   = row_cnt;
        flush_n = flush_cnt;
        pop     = 1'b0;
        ld      = 1'b0;
        zero    = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FEED;
                    row_n   = '0;
                    flush_n = '0;
                end
            end
            FEED: begin
                if (!empty) begin
                    pop   = 1'b1;
                    ld    = 1'b1;
                    row_n = row_cnt + 1'b1;
                    if (row_cnt == NW'(ELEMENT_COUNT - 1))
                        state_n = FLUSH;
                end
            end
            FLUSH: begin
                // One extra cycle after the zeros so done trails load_ena
                if (flush_cnt == NW'(ELEMENT_COUNT)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    ld      = 1'b1;
                    zero    = 1'b1;
                    flush_n = flush_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            flush_cnt  <= '0;
            packed_out <= '0;
            load_ena   <= 1'b0;
            done       <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            state     <= state_n;
            row_cnt   <= row_n;
            flush_cnt <= flush_n;
            load_ena  <= ld;
            done      <= done_n;
            s_ready   <= (count_n < CW'(FIFO_DEPTH));
            if (ld) packed_out <= zero ? '0 : head;
        end
    end

endmodule

// File: tb/tb_util_tile_feeder.sv
// Randomised and directed checks of util_tile_feeder against
// a queue-based transaction model of the tile protocol.
module tb_util_tile_feeder;

    localparam int EW = 16;
    localparam int EC = 4;
    localparam int D  = 8;
    localparam int W  = EW * EC;
    localparam logic [W-1:0] BASE = 64'h0001_0002_0003_0004;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] packed_out;
    logic         load_ena;
    logic         busy;
    logic         done;

    util_tile_feeder #(
        .ELEMENT_WIDTH(EW),
        .ELEMENT_COUNT(EC),
        .FIFO_DEPTH(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .packed_out(packed_out),
        .load_ena  (load_ena),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_out;
    bit           m_rdy, m_ena, m_busy, m_done;
    int           rows_left, zeros_left;
    int           dut_ena, dut_done;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0; m_rdy = 0; m_ena = 0; m_busy = 0; m_done = 0;
        rows_left = 0; zeros_left = 0;
    endtask

    // Tile = EC data rows (waiting for data as needed), EC zero rows,
    // then one quiet cycle ending in the done pulse.
    task automatic model_edge(input bit st, input bit v,
                              input logic [W-1:0] d);
        bit was_busy, accept;
        was_busy = m_busy;
        accept   = v && m_rdy;
        m_ena    = 0;
        m_done   = 0;
        if (was_busy) begin
            if (rows_left > 0) begin
                if (q.size() > 0) begin
                    m_out = q.pop_front();
                    m_ena = 1;
                    rows_left--;
                end
            end else if (zeros_left > 0) begin
                m_out = '0;
                m_ena = 1;
                zeros_left--;
            end else begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (st) begin
            m_busy     = 1;
            rows_left  = EC;
            zeros_left = EC;
        end
        if (accept) q.push_back(d);
        m_rdy = (q.size() < D);
    endtask

    task automatic compare(input string ph);
        chk({ph, ".s_ready"}, W'(s_ready), W'(m_rdy));
        chk({ph, ".load_ena"}, W'(load_ena), W'(m_ena));
        chk({ph, ".busy"}, W'(busy), W'(m_busy));
        chk({ph, ".done"}, W'(done), W'(m_done));
        chk({ph, ".packed_out"}, packed_out, m_out);
    endtask

    task automatic cyc(input string ph, input bit st, input bit v,
                       input logic [W-1:0] d);
        start   = st;
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        model_edge(st, v, d);
        @(negedge clk);
        compare(ph);
        if (load_ena === 1'b1) dut_ena++;
        if (done === 1'b1) dut_done++;
    endtask

    task automatic do_reset(input string ph);
        start = 0; s_valid = 0; s_data = '0;
        rst = 1'b1;
        #1;
        model_reset();
        compare({ph, ".in_rst"});
        @(negedge clk);
        compare({ph, ".in_rst2"});
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int e0, d0, pushed;
        rst = 1'b1; start = 0; s_valid = 0; s_data = '0;
        model_reset();
        @(negedge clk);
        compare("reset");
        rst = 1'b0;
        cyc("rel", 0, 0, '0);

        // Preloaded tile
        for (int i = 0; i < EC; i++) cyc("pre", 0, 1, BASE + W'(i));
        e0 = dut_ena; d0 = dut_done;
        cyc("pre", 1, 0, '0);
        repeat (12) cyc("pre", 0, 0, '0);
        chk("pre.ena_cycles", W'(dut_ena - e0), W'(2 * EC));
        chk("pre.done_pulses", W'(dut_done - d0), W'(1));

        // Stalled tile
        e0 = dut_ena;
        for (int i = 0; i < 2; i++) cyc("stall", 0, 1, BASE + W'(16 + i));
        cyc("stall", 1, 0, '0);
        repeat (5) cyc("stall", 0, 0, '0);
        cyc("stall", 0, 1, BASE + W'(18));
        cyc("stall", 0, 1, BASE + W'(19));
        repeat (12) cyc("stall", 0, 0, '0);
        chk("stall.ena_cycles", W'(dut_ena - e0), W'(2 * EC));

        // Fill to full, then free space
        repeat (12) cyc("fill", 0, 1, rnd());
        chk("fill.s_ready_low", W'(s_ready), W'(0));
        cyc("fill", 1, 1, rnd());
        repeat (14) cyc("fill", 0, 1, rnd());
        cyc("fill2", 1, 0, '0);
        repeat (12) cyc("fill2", 0, 0, '0);

        // Starts during FEED and FLUSH are ignored
        d0 = dut_done;
        cyc("ign", 1, 0, '0);
        cyc("ign", 0, 0, '0);
        cyc("ign", 1, 0, '0);
        repeat (4) cyc("ign", 0, 0, '0);
        cyc("ign", 1, 0, '0);
        repeat (6) cyc("ign", 0, 0, '0);
        chk("ign.done_pulses", W'(dut_done - d0), W'(1));

        // Reset mid-FEED with rows queued
        for (int i = 0; i < 3; i++) cyc("rmid", 0, 1, rnd());
        cyc("rmid", 1, 0, '0);
        do_reset("rmid");
        cyc("rmid.rel", 0, 0, '0);
        for (int i = 0; i < EC; i++) cyc("rmid", 0, 1, BASE + W'(32 + i));
        e0 = dut_ena;
        cyc("rmid", 1, 0, '0);
        repeat (12) cyc("rmid", 0, 0, '0);
        chk("rmid.ena_cycles", W'(dut_ena - e0), W'(2 * EC));

        // Three back-to-back tiles from 12 rows
        e0 = dut_ena; d0 = dut_done; pushed = 0;
        for (int i = 0; i < 50; i++) begin
            bit st, v;
            st = (i == 0) || (m_done && (dut_done - d0) < 3);
            v  = (pushed < 3 * EC);
            if (v && m_rdy) pushed++;
            cyc("b2b", st, v, BASE + W'(64 + pushed));
        end
        chk("b2b.done_pulses", W'(dut_done - d0), W'(3));
        chk("b2b.ena_cycles", W'(dut_ena - e0), W'(6 * EC));
        chk("b2b.idle_ready", W'(s_ready), W'(1));

        // Random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd");
                cyc("rnd.rel", 0, 0, '0);
            end else begin
                cyc("rnd", ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 2) != 0), rnd());
            end
        end
        repeat (16) cyc("tail", 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
